alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter OPW, default 3, ALU opcode width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req0_valid  in  1  requester 0 has an operation pending.
REQ-006 req0_ready  out  1  requester 0 operation accepted this edge.
REQ-007 req0_op / req0_rs / req0_rt  in  OPW/WIDTH/WIDTH  requester 0 opcode and operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_rs, req1_rt: same as REQ-005..007 for requester 1.
REQ-009 resp_valid  out  1  result available.
REQ-010 resp_ready  in  1  owning requester consumes result.
REQ-011 resp_id  out  1  requester index owning the result.
REQ-012 resp_result  out  WIDTH  captured ALU result.
REQ-013 resp_zero  out  1  captured ALU zero flag.
REQ-014 resp_err  out  1  opcode was illegal (101..111); no ALU use.
REQ-015 alu_op / alu_rs / alu_rt  out  OPW/WIDTH/WIDTH  registered drive to the shared ALU.
REQ-016 alu_result / alu_zero  in  WIDTH/1  from the shared ALU (result registered inside ALU, one-edge latency).
REQ-017 busy  out  1  high in any state except IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, CAPT, RESP; encoding free.
REQ-019 IDLE: if any reqN_valid, grant per REQ-020, assert that reqN_ready combinationally for that cycle only, latch op/rs/rt, record resp_id; legal op -> EXEC, illegal op -> RESP with resp_err=1, resp_result=0, resp_zero=0.
REQ-020 Arbitration round-robin: single valid wins; both valid -> requester not served last wins; after reset requester 0 has priority.
REQ-021 reqN_ready SHALL be 0 in EXEC, CAPT, RESP; at most one ready high per cycle.
REQ-022 alu_op/alu_rs/alu_rt SHALL update only on grant edge and hold stable through EXEC and CAPT.
REQ-023 EXEC: one cycle; ALU samples operands at its end -> CAPT.
REQ-024 CAPT: one cycle; resp_result<=alu_result, resp_zero<=alu_zero, resp_err<=0 -> RESP.
REQ-025 RESP: resp_valid=1; resp_id/result/zero/err held stable until resp_ready sampled high, then -> IDLE and last-served pointer updates to resp_id.
REQ-026 resp_valid SHALL be 0 in IDLE, EXEC, CAPT.
REQ-027 Latency: legal op, grant edge to resp_valid high = 3 clk edges; illegal op = 1 edge.
REQ-028 New grant only from IDLE; earliest re-grant is the cycle after the resp_ready handshake edge (no same-cycle response/accept overlap).
REQ-029 Requests changing or dropping while not ready SHALL be ignored; no data retained from non-granted cycles.
REQ-030 resp_ready while resp_valid=0 SHALL have no effect.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, all outputs 0 (alu_op/rs/rt=0, resp_*=0, busy=0, reqN_ready=0), priority pointer to requester 0.
REQ-032 rst_n asserted mid-operation (EXEC/CAPT/RESP) SHALL discard the operation; no response issued after release.
REQ-033 Deassertion takes effect at first posedge with rst_n high; a request valid then SHALL be granted that cycle.

Verification
REQ-034 req0 op=010 rs=5 rt=7, resp_ready=1 -> req0_ready pulse, resp_valid 3 edges later, resp_result=12, resp_id=0, resp_zero per ALU model.
REQ-035 both valid every cycle, ops 011 (9-4) and 000 -> grants alternate 0,1,0,1; results 5 and ALU-model value, ids match.
REQ-036 req1 op=110 -> resp_valid next edge, resp_err=1, resp_result=0, alu_* unchanged.
REQ-037 resp_ready held 0 for 10 cycles in RESP -> outputs stable, both readys 0, busy=1; release -> IDLE next edge.
REQ-038 rst_n low during CAPT -> all outputs 0 asynchronously, no resp_valid after release, first post-reset grant to requester 0 when both valid.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals around alu_arbiter.
// The slave side is the arbiter; the master side is everything around it
// (the two requesters, the response consumer and the shared ALU).
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_rs;
  logic [WIDTH-1:0] req0_rt;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_rs;
  logic [WIDTH-1:0] req1_rt;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_err;

  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_rs;
  logic [WIDTH-1:0] alu_rt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_rs, req0_rt,
    input  req1_valid, req1_op, req1_rs, req1_rt,
    input  resp_ready, alu_result, alu_zero,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result, resp_zero, resp_err,
    output alu_op, alu_rs, alu_rt
  );

  modport master (
    output req0_valid, req0_op, req0_rs, req0_rt,
    output req1_valid, req1_op, req1_rs, req1_rt,
    output resp_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result, resp_zero, resp_err,
    input  alu_op, alu_rs, alu_rt
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared, registered ALU.
// One operation is in flight at a time: grant -> EXEC -> CAPT -> RESP -> IDLE.
// Illegal opcodes skip the ALU and go straight to RESP with resp_err set.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t           state;
  state_t           state_nx;

  // Requester that wins a tie; flips to the other one after each completed response.
  logic             prio;

  logic             grant_any;
  logic             grant_id;
  logic [OPW-1:0]   gnt_op;
  logic [WIDTH-1:0] gnt_rs;
  logic [WIDTH-1:0] gnt_rt;
  logic             gnt_illegal;

  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] alu_rs_q;
  logic [WIDTH-1:0] alu_rt_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_result_q;
  logic             resp_zero_q;
  logic             resp_err_q;

  // Pick a winner while idle and mux its request; ready is gated by reset so nothing is accepted while held in reset.
  always_comb begin
    grant_any   = 1'b0;
    grant_id    = 1'b0;
    gnt_op      = '0;
    gnt_rs      = '0;
    gnt_rt      = '0;
    gnt_illegal = 1'b0;
    if (rst_n && state == IDLE && (bus.req0_valid || bus.req1_valid)) begin
      grant_any = 1'b1;
      grant_id  = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    end
    if (grant_id) begin
      gnt_op = bus.req1_op;
      gnt_rs = bus.req1_rs;
      gnt_rt = bus.req1_rt;
    end else begin
      gnt_op = bus.req0_op;
      gnt_rs = bus.req0_rs;
      gnt_rt = bus.req0_rt;
    end
    gnt_illegal = (gnt_op > OPW'(4));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; EXEC and CAPT are fixed single cycles, RESP waits for the consumer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nx = gnt_illegal ? RESP : EXEC;
        end
      end
      EXEC: state_nx = CAPT;
      CAPT: state_nx = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: ALU drive on a legal grant, response capture, and the round-robin pointer on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q      <= '0;
      alu_rs_q      <= '0;
      alu_rt_q      <= '0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      prio          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            resp_id_q <= grant_id;
            if (gnt_illegal) begin
              resp_err_q    <= 1'b1;
              resp_result_q <= '0;
              resp_zero_q   <= 1'b0;
            end else begin
              alu_op_q <= gnt_op;
              alu_rs_q <= gnt_rs;
              alu_rt_q <= gnt_rt;
            end
          end
        end
        CAPT: begin
          resp_result_q <= bus.alu_result;
          resp_zero_q   <= bus.alu_zero;
          resp_err_q    <= 1'b0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            prio <= ~resp_id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready  = grant_any && !grant_id;
  assign bus.req1_ready  = grant_any &&  grant_id;
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_zero   = resp_zero_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_rs      = alu_rs_q;
  assign bus.alu_rt      = alu_rt_q;
  assign busy            = (state != IDLE);

endmodule
